// File: rtl/lifo_stack_reg_pkg.sv
// lifo_stack_reg_pkg
//   Shared types for the register-file return stack (DR_RSTK slot).
//   stack_op_e names the four things the slot can be asked to do in a cycle;
//   decode_op maps the raw load/read strobes onto it.
package lifo_stack_reg_pkg;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11   // register moved onto itself: load and read together
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic load, input logic read);
        stack_op_e op;
        case ({read, load})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lifo_stack_reg.sv
// lifo_stack_reg
//   LIFO return stack occupying one register-file slot. Writing the slot
//   pushes, reading it pops; data_out always shows the current top (0 when
//   empty) straight from registered state, so the MCU consumes the value that
//   is visible in the cycle it asserts read.
//
//   Storage is a circular buffer: pushing while full overwrites the oldest
//   entry and sets the sticky overflow flag. Popping while empty sets the
//   sticky underflow flag. Both flags clear only on reset.
//
// Ports
//   sysclk     in   system clock, rising edge
//   sysreset   in   asynchronous active-high reset
//   data_out   out  top of stack, 0 when empty
//   data_in    in   value to push (r_load_data)
//   load       in   push strobe (r_load)
//   read       in   pop strobe (r_read)
//   count      out  number of valid entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky: push while full
//   underflow  out  sticky: pop while empty
module lifo_stack_reg
    import lifo_stack_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                       sysclk,
    input  logic                       sysreset,
    output logic [WIDTH-1:0]           data_out,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       load,
    input  logic                       read,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wp;
    logic [PW-1:0] wp_inc;
    logic [PW-1:0] wp_dec;
    stack_op_e     op;

    logic          mem_we;
    logic [PW-1:0] mem_waddr;

    // Explicit wrap so a non-power-of-two DEPTH still behaves modulo DEPTH.
    assign wp_inc = (wp == PTR_LAST) ? '0 : wp + PW'(1);
    assign wp_dec = (wp == '0) ? PTR_LAST : wp - PW'(1);

    assign op    = decode_op(load, read);
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // Top lives one slot below the write pointer.
    assign data_out = empty ? '0 : mem[wp_dec];

    // Storage write: replace overwrites the top in place, every other
    // write (push, or replace on an empty stack) goes to wp. A reset edge
    // suppresses the write so a discarded push leaves no trace.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wp;
        if (!sysreset) begin
            case (op)
                OP_PUSH: begin
                    mem_we = 1'b1;
                end
                OP_REPLACE: begin
                    mem_we    = 1'b1;
                    mem_waddr = empty ? wp : wp_dec;
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= data_in;
        end
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            wp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    wp <= wp_inc;
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        wp    <= wp_dec;
                        count <= count - CNT_ONE;
                    end
                end
                OP_REPLACE: begin
                    // On an empty stack this is a plain push; otherwise the
                    // top is rewritten and pointer/count hold.
                    if (empty) begin
                        wp    <= wp_inc;
                        count <= CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_stack_reg.sv
// tb_lifo_stack_reg
//   Directed plan followed by randomized load/read traffic, compared each
//   cycle against a queue-based model of the stack.
module tb_lifo_stack_reg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic             sysclk = 1'b0;
    logic             sysreset;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             read;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    // Model: back of the queue is the top of stack.
    logic [WIDTH-1:0] m_q [$];
    logic             m_ovf;
    logic             m_unf;

    lifo_stack_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sysclk    (sysclk),
        .sysreset  (sysreset),
        .data_out  (data_out),
        .data_in   (data_in),
        .load      (load),
        .read      (read),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic r, input logic [WIDTH-1:0] d);
        if (l && r) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = d;
            else                m_q.push_back(d);
        end else if (l) begin
            m_q.push_back(d);
            if (m_q.size() > DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
        end else if (r) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else                m_unf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] top;
        top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
        check({tag, ".data_out"},  32'(data_out),  32'(top));
        check({tag, ".count"},     32'(count),     32'(m_q.size()));
        check({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
        check({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic cycle(input string tag, input logic l, input logic r, input logic [WIDTH-1:0] d);
        load    = l;
        read    = r;
        data_in = d;
        @(posedge sysclk);
        model_step(l, r, d);
        #1;
        load    = 1'b0;
        read    = 1'b0;
        data_in = '0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(posedge sysclk);
        #2;
        sysreset = 1'b1;
        #1;
        model_reset();
        @(posedge sysclk);
        #1;
        sysreset = 1'b0;
        check_all("reset");
    endtask

    initial begin
        sysreset = 1'b1;
        load     = 1'b0;
        read     = 1'b0;
        data_in  = '0;
        model_reset();
        #12;
        sysreset = 1'b0;
        #1;
        check_all("por");
        cycle("idle", 1'b0, 1'b0, '0);

        // Push three, pop three.
        cycle("push1", 1'b1, 1'b0, 16'h1111);
        cycle("push2", 1'b1, 1'b0, 16'h2222);
        cycle("push3", 1'b1, 1'b0, 16'h3333);
        check("top3333", 32'(data_out), 32'h3333);
        cycle("pop1", 1'b0, 1'b1, '0);
        check("top2222", 32'(data_out), 32'h2222);
        cycle("pop2", 1'b0, 1'b1, '0);
        cycle("pop3", 1'b0, 1'b1, '0);
        check("empty_after_pops", 32'(empty), 32'd1);

        // Pop while empty; flag must stick across later traffic.
        cycle("pop_empty", 1'b0, 1'b1, '0);
        check("unf_set", 32'(underflow), 32'd1);
        cycle("push_after_unf", 1'b1, 1'b0, 16'h5555);
        cycle("pop_after_unf", 1'b0, 1'b1, '0);
        check("unf_sticky", 32'(underflow), 32'd1);
        do_reset();

        // Fill past capacity.
        for (int i = 0; i < 33; i++) begin
            cycle("fill", 1'b1, 1'b0, WIDTH'(i));
            if (i == 31) begin
                check("full_at_32", 32'(full), 32'd1);
                check("no_ovf_at_32", 32'(overflow), 32'd0);
            end
        end
        check("ovf_at_33", 32'(overflow), 32'd1);
        check("top_32", 32'(data_out), 32'd32);
        for (int i = 0; i < 31; i++) cycle("drain", 1'b0, 1'b1, '0);
        check("top_1", 32'(data_out), 32'd1);
        cycle("drain_last", 1'b0, 1'b1, '0);
        check("zero_lost", 32'(empty), 32'd1);
        do_reset();

        // Replace top.
        cycle("pushA", 1'b1, 1'b0, 16'hAAAA);
        cycle("pushB", 1'b1, 1'b0, 16'hBBBB);
        cycle("replace", 1'b1, 1'b1, 16'hCCCC);
        check("replace_top", 32'(data_out), 32'hCCCC);
        check("replace_cnt", 32'(count), 32'd2);
        cycle("pop_after_rep", 1'b0, 1'b1, '0);
        check("top_AAAA", 32'(data_out), 32'hAAAA);
        cycle("pop_rest", 1'b0, 1'b1, '0);
        cycle("replace_empty", 1'b1, 1'b1, 16'h7777);
        check("rep_empty_unf", 32'(underflow), 32'd0);
        do_reset();

        // Asynchronous reset mid-cycle with a push pending.
        cycle("push1234", 1'b1, 1'b0, 16'h1234);
        load    = 1'b1;
        data_in = 16'h9999;
        #2;
        sysreset = 1'b1;
        #1;
        check("async_cnt", 32'(count), 32'd0);
        check("async_dout", 32'(data_out), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        @(posedge sysclk);
        #1;
        load     = 1'b0;
        data_in  = '0;
        sysreset = 1'b0;
        model_reset();
        check_all("after_async");
        cycle("idle_after_async", 1'b0, 1'b0, '0);

        // Randomized traffic, biased in phases toward filling and draining.
        for (int i = 0; i < 1500; i++) begin
            int unsigned bias;
            logic l, r;
            bias = ((i / 150) % 2 == 0) ? 70 : 30;
            l = ($urandom_range(99) < bias);
            r = ($urandom_range(99) < (100 - bias));
            cycle("rand", l, r, WIDTH'($urandom));
            if ($urandom_range(499) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
